// File: rtl/josh_pkg.sv
// Shared types and constants for the jump-game controller slice.
// The JOSH_PAUSE_EN build option adds a pause input; the package itself does not change.
package josh_pkg;

  localparam int TICK_DIV_DEF = 833333;
  localparam int SCORE_W_DEF  = 8;

  localparam logic GRAV_DOWN = 1'b0;
  localparam logic GRAV_UP   = 1'b1;

  typedef enum logic [3:0] {
    S_MENU       = 4'd0,
    S_MENU_WAIT  = 4'd1,
    S_WAIT_TICK  = 4'd2,
    S_ERASE      = 4'd3,
    S_ERASE_WAIT = 4'd4,
    S_UPDATE     = 4'd5,
    S_CHECK      = 4'd6,
    S_DRAW       = 4'd7,
    S_DRAW_WAIT  = 4'd8,
    S_OVER       = 4'd9,
    S_OVER_WAIT  = 4'd10
  } state_t;

  function automatic logic in_game(input state_t s);
    case (s)
      S_WAIT_TICK, S_ERASE, S_ERASE_WAIT, S_UPDATE,
      S_CHECK, S_DRAW, S_DRAW_WAIT: in_game = 1'b1;
      default:                      in_game = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game sequencer and its datapath, plotter and buttons.
// With JOSH_PAUSE_EN defined the bundle also carries the pause button.
interface game_sequencer_if #(parameter int SCORE_W = josh_pkg::SCORE_W_DEF);

  logic go;
  logic grav;
  logic collide;
  logic draw_done;
`ifdef JOSH_PAUSE_EN
  logic pause;
`endif
  logic startgame;
  logic draw_req;
  logic erase;
  logic ld_pos;
  logic grav_dir;
  logic endgame;
  logic [SCORE_W-1:0] score;

  modport master (
`ifdef JOSH_PAUSE_EN
    input  pause,
`endif
    input  go, grav, collide, draw_done,
    output startgame, draw_req, erase, ld_pos, grav_dir, endgame, score
  );

  modport slave (
`ifdef JOSH_PAUSE_EN
    output pause,
`endif
    output go, grav, collide, draw_done,
    input  startgame, draw_req, erase, ld_pos, grav_dir, endgame, score
  );

endinterface

// File: rtl/game_sequencer_frame_tick_gen.sv
// Frame-rate divider: one-cycle tick every TICK_DIV enabled cycles, counter cleared while disabled.
// With JOSH_PAUSE_EN defined a hold input freezes the count without clearing it.
module frame_tick_gen #(
  parameter int TICK_DIV = josh_pkg::TICK_DIV_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
`ifdef JOSH_PAUSE_EN
  input  logic hold,
`endif
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             hold_s;

`ifdef JOSH_PAUSE_EN
  assign hold_s = hold;
`else
  assign hold_s = 1'b0;
`endif

  // Free-running frame counter, wrapping at TICK_DIV-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
    end else if (!en) begin
      cnt_r <= '0;
    end else if (hold_s) begin
      cnt_r <= cnt_r;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign tick = en && !hold_s && (cnt_r == CNT_MAX);

endmodule

// File: rtl/game_sequencer.sv
// Jump-game top-level sequencer: menu/game/over phases, per-frame pipeline, gravity latch, score.
// Defining JOSH_PAUSE_EN adds a pause button that freezes play between frames.
module game_sequencer
  import josh_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int SCORE_W  = SCORE_W_DEF
) (
  input logic              clk,
  input logic              resetn,
  game_sequencer_if.master bus
);

  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t             state_r, state_nxt_s;
  logic               in_game_s, start_s, tick_s, tick_pending_r, paused_s;
  logic               grav_prev_r, grav_rise_s, grav_dir_r;
  logic [SCORE_W-1:0] score_r;
  logic               startgame_r, draw_req_r, erase_r, ld_pos_r, endgame_r;
  logic               startgame_nxt_s, draw_req_nxt_s, erase_nxt_s, ld_pos_nxt_s, endgame_nxt_s;

  assign in_game_s   = in_game(state_r);
  assign start_s     = (state_r == S_MENU_WAIT) && !bus.go;
  assign grav_rise_s = bus.grav && !grav_prev_r;

`ifdef JOSH_PAUSE_EN
  logic pause_prev_r, paused_r;

  // Pause flag: toggled between frames only, dropped when the game is left.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pause_prev_r <= 1'b0;
      paused_r     <= 1'b0;
    end else begin
      pause_prev_r <= bus.pause;
      if (!in_game_s) begin
        paused_r <= 1'b0;
      end else if ((state_r == S_WAIT_TICK) && bus.pause && !pause_prev_r) begin
        paused_r <= !paused_r;
      end else begin
        paused_r <= paused_r;
      end
    end
  end

  assign paused_s = paused_r;
`else
  assign paused_s = 1'b0;
`endif

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .en     (in_game_s),
`ifdef JOSH_PAUSE_EN
    .hold   (paused_s),
`endif
    .tick   (tick_s)
  );

  // One-deep frame queue; a new tick beats a same-cycle consume.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_pending_r <= 1'b0;
    end else if (paused_s) begin
      tick_pending_r <= 1'b0;
    end else if (tick_s) begin
      tick_pending_r <= 1'b1;
    end else if (state_r == S_WAIT_TICK) begin
      tick_pending_r <= 1'b0;
    end else begin
      tick_pending_r <= tick_pending_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_MENU;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_MENU:       if (bus.go)         state_nxt_s = S_MENU_WAIT;  else state_nxt_s = state_r;
      S_MENU_WAIT:  if (!bus.go)        state_nxt_s = S_WAIT_TICK;  else state_nxt_s = state_r;
      S_WAIT_TICK:  if (tick_pending_r && !paused_s)
                                        state_nxt_s = S_ERASE;      else state_nxt_s = state_r;
      S_ERASE:                          state_nxt_s = S_ERASE_WAIT;
      S_ERASE_WAIT: if (bus.draw_done)  state_nxt_s = S_UPDATE;     else state_nxt_s = state_r;
      S_UPDATE:                         state_nxt_s = S_CHECK;
      S_CHECK:      if (bus.collide)    state_nxt_s = S_OVER;       else state_nxt_s = S_DRAW;
      S_DRAW:                           state_nxt_s = S_DRAW_WAIT;
      S_DRAW_WAIT:  if (bus.draw_done)  state_nxt_s = S_WAIT_TICK;  else state_nxt_s = state_r;
      S_OVER:       if (bus.go)         state_nxt_s = S_OVER_WAIT;  else state_nxt_s = state_r;
      S_OVER_WAIT:  if (!bus.go)        state_nxt_s = S_MENU;       else state_nxt_s = state_r;
      default:                          state_nxt_s = S_MENU;
    endcase
  end

  // Moore outputs decoded from the upcoming state so they can be registered without lag.
  always_comb begin
    startgame_nxt_s = in_game(state_nxt_s);
    draw_req_nxt_s  = (state_nxt_s == S_ERASE) || (state_nxt_s == S_DRAW);
    erase_nxt_s     = (state_nxt_s == S_ERASE);
    ld_pos_nxt_s    = (state_nxt_s == S_UPDATE);
    endgame_nxt_s   = (state_nxt_s == S_OVER) || (state_nxt_s == S_OVER_WAIT);
  end

  // Output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      startgame_r <= 1'b0;
      draw_req_r  <= 1'b0;
      erase_r     <= 1'b0;
      ld_pos_r    <= 1'b0;
      endgame_r   <= 1'b0;
    end else begin
      startgame_r <= startgame_nxt_s;
      draw_req_r  <= draw_req_nxt_s;
      erase_r     <= erase_nxt_s;
      ld_pos_r    <= ld_pos_nxt_s;
      endgame_r   <= endgame_nxt_s;
    end
  end

  // Gravity latch: button edges flip direction only during play.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grav_prev_r <= 1'b0;
      grav_dir_r  <= GRAV_DOWN;
    end else begin
      grav_prev_r <= bus.grav;
      if (start_s) begin
        grav_dir_r <= GRAV_DOWN;
      end else if (grav_rise_s && in_game_s && !paused_s) begin
        grav_dir_r <= !grav_dir_r;
      end else begin
        grav_dir_r <= grav_dir_r;
      end
    end
  end

  // Saturating count of completed frames; held after game over until the next start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      score_r <= '0;
    end else if (start_s) begin
      score_r <= '0;
    end else if ((state_r == S_DRAW_WAIT) && bus.draw_done && (score_r != SCORE_MAX)) begin
      score_r <= score_r + SCORE_ONE;
    end else begin
      score_r <= score_r;
    end
  end

  assign bus.startgame = startgame_r;
  assign bus.draw_req  = draw_req_r;
  assign bus.erase     = erase_r;
  assign bus.ld_pos    = ld_pos_r;
  assign bus.grav_dir  = grav_dir_r;
  assign bus.endgame   = endgame_r;
  assign bus.score     = score_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: two instances (8-bit and 2-bit score) on shared stimulus,
// checked every cycle against a mode/step game model, plus directed literal checks.
module tb_game_sequencer;

  localparam int TD = 4;
  localparam int MD_MENU = 0, MD_GAME = 1, MD_OVER = 2;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic go = 1'b0, grav = 1'b0, collide = 1'b0, draw_done = 1'b0;

  always #5 clk = ~clk;

  game_sequencer_if #(.SCORE_W(8)) bus_a ();
  game_sequencer_if #(.SCORE_W(2)) bus_b ();

  assign bus_a.go = go;        assign bus_b.go = go;
  assign bus_a.grav = grav;    assign bus_b.grav = grav;
  assign bus_a.collide = collide;     assign bus_b.collide = collide;
  assign bus_a.draw_done = draw_done; assign bus_b.draw_done = draw_done;
`ifdef JOSH_PAUSE_EN
  assign bus_a.pause = 1'b0;   assign bus_b.pause = 1'b0;
`endif

  game_sequencer #(.TICK_DIV(TD), .SCORE_W(8)) dut_a (.clk(clk), .resetn(resetn), .bus(bus_a.master));
  game_sequencer #(.TICK_DIV(TD), .SCORE_W(2)) dut_b (.clk(clk), .resetn(resetn), .bus(bus_b.master));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: menu / game / over; held = go pressed, waiting for release.
  // step within a frame: 0 wait tick, 1 erase request, 2 erase busy, 3 update,
  // 4 collision check, 5 draw request, 6 draw busy.
  int m_mode = MD_MENU, m_step = 0, m_gcyc = 0, m_frames = 0;
  bit m_held = 1'b0, m_queued = 1'b0, m_dir = 1'b0, m_gprev = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode <= MD_MENU; m_step <= 0; m_gcyc <= 0; m_frames <= 0;
      m_held <= 1'b0; m_queued <= 1'b0; m_dir <= 1'b0; m_gprev <= 1'b0;
    end else begin : mstep
      bit ing, tk, held_n, dir_n;
      int mode_n, step_n, frames_n;
      ing = (m_mode == MD_GAME);
      tk = ing && ((m_gcyc % TD) == (TD - 1));
      mode_n = m_mode; step_n = m_step; held_n = m_held; frames_n = m_frames; dir_n = m_dir;
      if (ing && grav && !m_gprev) dir_n = !m_dir;
      if (!ing) begin
        if (!m_held) held_n = go;
        else if (!go) begin
          held_n = 1'b0;
          if (m_mode == MD_MENU) begin
            mode_n = MD_GAME; step_n = 0; frames_n = 0; dir_n = 1'b0;
          end else mode_n = MD_MENU;
        end
      end else begin
        case (m_step)
          0: if (m_queued) step_n = 1;
          1: step_n = 2;
          2: if (draw_done) step_n = 3;
          3: step_n = 4;
          4: if (collide) mode_n = MD_OVER; else step_n = 5;
          5: step_n = 6;
          6: if (draw_done) begin frames_n = m_frames + 1; step_n = 0; end
          default: step_n = 0;
        endcase
      end
      m_queued <= tk ? 1'b1 : ((ing && m_step == 0) ? 1'b0 : m_queued);
      m_gcyc <= ing ? m_gcyc + 1 : 0;
      m_mode <= mode_n; m_step <= step_n; m_held <= held_n;
      m_frames <= frames_n; m_dir <= dir_n; m_gprev <= grav;
    end
  end

  function automatic bit e_game();
    return m_mode == MD_GAME;
  endfunction

  task automatic cmp_dut(input string t, input logic sg, input logic dr, input logic er,
                         input logic ld, input logic gd, input logic eg, input int sc, input int smax);
    chk({t, "startgame"}, sg, e_game());
    chk({t, "draw_req"}, dr, e_game() && (m_step == 1 || m_step == 5));
    chk({t, "erase"}, er, e_game() && m_step == 1);
    chk({t, "ld_pos"}, ld, e_game() && m_step == 3);
    chk({t, "grav_dir"}, gd, m_dir);
    chk({t, "endgame"}, eg, m_mode == MD_OVER);
    chk({t, "score"}, sc, (m_frames < smax) ? m_frames : smax);
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    cmp_dut("a.", bus_a.startgame, bus_a.draw_req, bus_a.erase, bus_a.ld_pos,
            bus_a.grav_dir, bus_a.endgame, int'(bus_a.score), 255);
    cmp_dut("b.", bus_b.startgame, bus_b.draw_req, bus_b.erase, bus_b.ld_pos,
            bus_b.grav_dir, bus_b.endgame, int'(bus_b.score), 3);
  end

  // ---------------- plotter responder ----------------
  int resp_delay = 3;
  bit hold_next = 1'b0;
  bit spur_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus_a.draw_req) begin
        int d;
        d = resp_delay;
        if (hold_next && !bus_a.erase) begin
          d = 3 * TD;
          hold_next = 1'b0;
        end
        repeat (d) @(posedge clk);
        #1 draw_done = 1'b1;
        @(posedge clk);
        #1 draw_done = 1'b0;
      end else if (spur_en && $urandom_range(15, 0) == 0) begin
        @(posedge clk);
        #1 draw_done = 1'b1;
        @(posedge clk);
        #1 draw_done = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit cond(input int sel, input int val);
    case (sel)
      0: return bus_a.startgame == 1'b1;
      1: return bus_a.draw_req && bus_a.erase;
      2: return bus_a.draw_req && !bus_a.erase;
      3: return bus_a.endgame == 1'b1;
      4: return int'(bus_a.score) == val;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int val, input int budget, input string name);
    int n;
    n = 0;
    while (!cond(sel, val) && n < budget) begin
      cyc(1);
      n++;
    end
    chk({name, "_reached"}, cond(sel, val), 1);
  endtask

  task automatic press_go();
    go = 1'b1;
    cyc(2);
    go = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_grav();
    grav = 1'b1;
    cyc(1);
    grav = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, s0;
    #2 resetn = 1'b0;
    cyc(3);
    chk("rst_startgame", bus_a.startgame, 0);
    chk("rst_draw_req", bus_a.draw_req, 0);
    chk("rst_score", int'(bus_a.score), 0);
    chk("rst_endgame", bus_a.endgame, 0);
    resetn = 1'b1;
    cyc(2);

    pulse_grav();
    cyc(2);
    chk("menu_grav_ignored", bus_a.grav_dir, 0);

    // Game 1: start latency, five frames, gravity toggles, overrun, collision.
    press_go();
    chk("start_rise", bus_a.startgame, 1);
    n = 0;
    while (!cond(1, 0) && n < 20) begin cyc(1); n++; end
    chk("first_erase_min", n >= 4, 1);
    chk("first_erase_max", n <= 5, 1);
    chk("first_score", int'(bus_a.score), 0);

    wait_until(4, 5, 200, "five_frames");
    chk("score_a_5", int'(bus_a.score), 5);
    chk("score_b_sat", int'(bus_b.score), 3);

    cyc(2); pulse_grav(); chk("grav_t2", bus_a.grav_dir, 1);
    cyc(2); pulse_grav(); chk("grav_t5", bus_a.grav_dir, 0);
    cyc(3); pulse_grav(); chk("grav_t9", bus_a.grav_dir, 1);

    hold_next = 1'b1;
    wait_until(2, 0, 60, "hold_draw");
    s0 = int'(bus_a.score);
    n = 0;
    while (int'(bus_a.score) == s0 && n < 60) begin cyc(1); n++; end
    chk("hold_released", int'(bus_a.score), s0 + 1);
    n = 0;
    while (!cond(1, 0) && n < 10) begin cyc(1); n++; end
    chk("overrun_latency", n, 1);

    collide = 1'b1;
    wait_until(3, 0, 60, "endgame1");
    collide = 1'b0;
    press_go();
    cyc(1);
    chk("menu_after_over", bus_a.startgame | bus_a.endgame, 0);

    // Game 2: collide in the check of frame 3.
    press_go();
    wait_until(4, 2, 200, "two_frames");
    collide = 1'b1;
    wait_until(3, 0, 60, "endgame2");
    chk("collide_score", int'(bus_a.score), 2);
    cyc(6);
    collide = 1'b0;
    press_go();
    cyc(1);
    chk("menu_score_held", int'(bus_a.score), 2);
    chk("menu_endgame", bus_a.endgame, 0);

    // Game 3: asynchronous reset in the middle of a draw wait.
    press_go();
    pulse_grav();
    wait_until(4, 2, 200, "g3_frames");
    wait_until(2, 0, 40, "g3_draw");
    cyc(1);
    #2 resetn = 1'b0;
    #1;
    chk("async_startgame", bus_a.startgame, 0);
    chk("async_score_a", int'(bus_a.score), 0);
    chk("async_score_b", int'(bus_b.score), 0);
    chk("async_grav_dir", bus_a.grav_dir, 0);
    cyc(1);
    resetn = 1'b1;
    cyc(6);
    chk("post_rst_startgame", bus_a.startgame, 0);
    chk("post_rst_score", int'(bus_a.score), 0);

    // Random play, including spurious plotter completions and one extra reset.
    spur_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5, 0) == 0) go = ~go;
      grav = ($urandom_range(3, 0) == 0);
      collide = ($urandom_range(9, 0) == 0);
      resp_delay = $urandom_range(6, 1);
      if (i == 800) begin
        #2 resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
      end
      cyc(1);
    end
    spur_en = 1'b0;
    go = 1'b0; grav = 1'b0; collide = 1'b0;
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller for the jump game.
- Sequences the game datapath and the pixel plotter through menu, game and game-over phases.
- Within a game, runs a fixed per-frame pipeline: wait tick, erase, update, collision check, draw.
- Also owns the frame-rate tick divider, the gravity-flip latch and the score counter.

Parameters:
- TICK_DIV, 833333, clk cycles per frame tick (60 Hz at 50 MHz); must be ≥ 2.
- SCORE_W, 8, score counter width.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- go  input  1  start/acknowledge button, active-high, already synchronised.
- grav  input  1  gravity-flip button, active-high, already synchronised.
- collide  input  1  datapath collision flag; valid in S_CHECK.
- draw_done  input  1  plotter completion pulse, one cycle.
- startgame  output  1  high in all in-game states.
- draw_req  output  1  one-cycle plotter start pulse.
- erase  output  1  qualifies draw_req: 1 = erase old sprite, 0 = draw new sprite.
- ld_pos  output  1  one-cycle datapath position/wall update strobe.
- grav_dir  output  1  current gravity direction: 0 = down, 1 = up.
- endgame  output  1  high in S_OVER and S_OVER_WAIT.
- score  output  SCORE_W  frames survived.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state goes to S_MENU; tick counter = 0; tick_pending = 0.
  - All outputs 0, including score and grav_dir.
  - Reset mid-frame abandons any outstanding plotter request; a later draw_done is ignored.
- FSM (registered state, Moore outputs):
  - S_MENU: go=1 -> S_MENU_WAIT.
  - S_MENU_WAIT: waits for go=0, then -> S_WAIT_TICK. On that transition: score cleared, grav_dir cleared, tick counter cleared.
  - S_WAIT_TICK: tick_pending=1 -> S_ERASE, clearing tick_pending.
  - S_ERASE: draw_req=1 and erase=1 for exactly one cycle -> S_ERASE_WAIT.
  - S_ERASE_WAIT: draw_done=1 -> S_UPDATE.
  - S_UPDATE: ld_pos=1 for one cycle -> S_CHECK.
  - S_CHECK: collide=1 -> S_OVER; otherwise -> S_DRAW.
  - S_DRAW: draw_req=1 and erase=0 for one cycle -> S_DRAW_WAIT.
  - S_DRAW_WAIT: draw_done=1 -> score increments, then -> S_WAIT_TICK.
  - S_OVER: go=1 -> S_OVER_WAIT.
  - S_OVER_WAIT: go=0 -> S_MENU. Score holds until the next game start.
- Tick generator:
  - Counts 0..TICK_DIV-1 only while startgame=1, then wraps to 0.
  - Asserts tick for one cycle when count = TICK_DIV-1; tick sets tick_pending.
  - A tick while tick_pending is already 1 is dropped, so at most one frame is queued.
  - If tick and the S_WAIT_TICK consume happen in the same cycle, the set wins and tick_pending stays 1.
- Gravity:
  - grav is edge-detected with one register.
  - A rising edge toggles grav_dir only while startgame=1; edges in menu or game-over are ignored.
  - grav_dir changes take effect immediately; the datapath samples it at ld_pos.
- Score:
  - SCORE_W-bit, saturates at all-ones (255 with the default width) and does not wrap.
- draw_done arriving in any state other than S_ERASE_WAIT or S_DRAW_WAIT is ignored.
- Latency:
  - Minimum frame length: tick -> S_ERASE takes 1 cycle.
  - Full frame = 6 cycles plus the two plotter durations.

Optional Feature:
- Macro: JOSH_PAUSE_EN.
- When defined:
  - Adds input pause (1 bit, synchronised).
  - A rising edge of pause toggles a paused flag, and only while in S_WAIT_TICK.
  - While paused: the tick counter freezes, tick_pending is held at 0, and the FSM stays in S_WAIT_TICK.
  - grav edges are ignored while paused.
  - paused clears on reset and on leaving the game.
- When undefined: no pause port and no paused logic; behaviour is exactly as above.

Decomposition:
- Shared package josh_pkg holds:
  - state enum (11 states, 4-bit encoding);
  - default TICK_DIV and SCORE_W constants;
  - grav_dir encoding constants GRAV_DOWN and GRAV_UP.
- One sub-module, frame_tick_gen:
  - parameter TICK_DIV; ports clk, resetn, en, tick;
  - counter cleared whenever en=0.
- The FSM, gravity latch and score logic stay in game_sequencer.

Test Plan:
- TICK_DIV=4, reset, then go pulse -> startgame rises on the cycle go falls; first draw_req with erase=1 appears 4–5 cycles later; score=0.
- Normal frame with draw_done returned 3 cycles after each draw_req and collide=0 -> sequence is erase req, ld_pos, draw req with erase=0; score increments by 1 per frame; 5 frames give score=5.
- Collision: collide=1 in S_CHECK of frame 3 -> endgame=1, no further draw_req, score=2; go press then release -> S_MENU with score still 2.
- Overrun: hold draw_done off for 3×TICK_DIV cycles -> exactly one extra frame runs after release (one tick queued), never two.
- grav pulses at 2, 5, 9 during game -> grav_dir toggles 1, 0, 1; a grav pulse in menu leaves grav_dir=0; resetn low mid-S_DRAW_WAIT -> all outputs 0 immediately (asynchronous), and a draw_done after reset is ignored.
- Score saturation with SCORE_W=2 -> after 3 frames score stays at 3 through frames 4 and 5.
